// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and
// latches branch redirects that arrive while the PC is frozen.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
  parameter int          STALL_W  = 6,
  parameter int          CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  output logic [32:0]        if_to_id_bus,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata,
  output logic               if_adel,
  output logic [CNT_W-1:0]   fetch_cnt
);

  localparam logic STOP = 1'b1;

  logic [31:0]      pc_reg;
  logic             ce_reg;
  logic             pend_valid;
  logic [31:0]      pend_addr;
  logic [CNT_W-1:0] cnt_reg;

  logic        br_e;
  logic [31:0] br_addr;
  logic        pc_stop;
  logic [31:0] next_pc;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign pc_stop = (stall[0] == STOP);

  // A live redirect beats a buffered one; the buffered one beats sequential fetch.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e)            next_pc = br_addr;
    else if (pend_valid) next_pc = pend_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      ce_reg     <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
      cnt_reg    <= '0;
    end else if (!pc_stop) begin
      pc_reg     <= next_pc;
      ce_reg     <= 1'b1;
      pend_valid <= 1'b0;
      if (ce_reg) cnt_reg <= cnt_reg + 1'b1;
    end else if (br_e) begin
      // Newest redirect wins if several land during one stall.
      pend_valid <= 1'b1;
      pend_addr  <= br_addr;
    end
  end

  assign inst_sram_en    = ce_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wdata = 32'd0;
  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign if_adel         = ce_reg & (pc_reg[1:0] != 2'b00);
  assign fetch_cnt       = cnt_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: driver pushes hand-computed expectations,
// monitor pops and compares one entry per clock.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        if_adel;
  logic [31:0] fetch_cnt;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .if_to_id_bus(if_to_id_bus), .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .if_adel(if_adel), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        adel;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Expectation describes DUT outputs after the next rising edge.
  task automatic vec(input logic r, input logic s, input logic be, input logic [31:0] ba,
                     input logic ece, input logic [31:0] epc, input logic [31:0] ecnt,
                     input logic eadel);
    @(negedge clk);
    rst    = r;
    stall  = {5'b10101, s};
    br_bus = {be, ba};
    q.push_back({ece, epc, ecnt, eadel});
  endtask

  initial begin : monitor
    exp_t e;
    int   idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        idx++;
        chk("bus",   idx, {31'd0, if_to_id_bus}, {31'd0, e.ce, e.pc});
        chk("addr",  idx, {32'd0, inst_sram_addr}, {32'd0, e.pc});
        chk("en",    idx, {63'd0, inst_sram_en}, {63'd0, e.ce});
        chk("cnt",   idx, {32'd0, fetch_cnt}, {32'd0, e.cnt});
        chk("adel",  idx, {63'd0, if_adel}, {63'd0, e.adel});
        chk("wr",    idx, {28'd0, inst_sram_wen, inst_sram_wdata}, 64'd0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int waitc;
    rst = 1'b1; stall = 6'd0; br_bus = 33'd0;
    // reset
    vec(1,0,0,32'h0,          0,32'hBFBF_FFFC,0,0);
    vec(1,0,1,32'h1234_5678,  0,32'hBFBF_FFFC,0,0);
    vec(1,1,0,32'h0,          0,32'hBFBF_FFFC,0,0);
    // sequential fetch
    vec(0,0,0,32'h0,          1,32'hBFC0_0000,0,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0004,1,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0008,2,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_000C,3,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0010,4,0);
    // taken branch
    vec(0,0,1,32'hBFC0_0100,  1,32'hBFC0_0100,5,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0104,6,0);
    vec(0,0,1,32'hBFC0_0020,  1,32'hBFC0_0020,7,0);
    // redirect during stall
    vec(0,1,1,32'hBFC0_0200,  1,32'hBFC0_0020,7,0);
    vec(0,1,0,32'h0,          1,32'hBFC0_0020,7,0);
    vec(0,1,0,32'h0,          1,32'hBFC0_0020,7,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0200,8,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0204,9,0);
    // overwrite, then live branch wins at release
    vec(0,1,1,32'hBFC0_0300,  1,32'hBFC0_0204,9,0);
    vec(0,1,1,32'hBFC0_0400,  1,32'hBFC0_0204,9,0);
    vec(0,0,1,32'hBFC0_0500,  1,32'hBFC0_0500,10,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0504,11,0);
    // overwrite, release without branch uses newest pending
    vec(0,1,1,32'hBFC0_0300,  1,32'hBFC0_0504,11,0);
    vec(0,1,1,32'hBFC0_0400,  1,32'hBFC0_0504,11,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0400,12,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0404,13,0);
    // misaligned redirect
    vec(0,0,1,32'hBFC0_0002,  1,32'hBFC0_0002,14,1);
    vec(0,0,0,32'h0,          1,32'hBFC0_0006,15,1);
    vec(0,0,1,32'hBFC0_0008,  1,32'hBFC0_0008,16,0);
    // wrap
    vec(0,0,1,32'hFFFF_FFFC,  1,32'hFFFF_FFFC,17,0);
    vec(0,0,0,32'h0,          1,32'h0000_0000,18,0);
    vec(0,0,0,32'h0,          1,32'h0000_0004,19,0);
    // reset mid-stall discards pending
    vec(0,1,1,32'hBFC0_0600,  1,32'h0000_0004,19,0);
    vec(1,1,1,32'hBFC0_0700,  0,32'hBFBF_FFFC,0,0);
    vec(1,0,0,32'h0,          0,32'hBFBF_FFFC,0,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0000,0,0);
    vec(0,0,0,32'h0,          1,32'hBFC0_0004,1,0);
    vec(0,1,0,32'h0,          1,32'hBFC0_0004,1,0);
    waitc = 0;
    while (q.size() > 0 && waitc < 10) begin
      @(posedge clk);
      waitc++;
    end
    #2;
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
